// File: rtl/adder_axi_pkg.sv
// Shared definitions for the AXI4-Lite adder peripheral: register offsets,
// response codes, the data word type and a byte-strobe merge helper.
package adder_axi_pkg;

  typedef logic [31:0] data_t;

  localparam logic [3:0] ADDR_OP_A   = 4'h0;
  localparam logic [3:0] ADDR_OP_B   = 4'h4;
  localparam logic [3:0] ADDR_SUM    = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic data_t apply_wstrb(input data_t old_val, input data_t new_val,
                                        input logic [3:0] strb);
    data_t res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_core.sv
// Combinational 32-bit adder. With ADDER_CARRY_OUT_EN defined the 33rd bit is
// produced as carry_o; otherwise carry_o is tied low.
module adder_core
  import adder_axi_pkg::*;
(
  input  data_t op_a_i,
  input  data_t op_b_i,
  output data_t sum_o,
  output logic  carry_o
);

`ifdef ADDER_CARRY_OUT_EN
  logic [32:0] full_sum;
  assign full_sum = {1'b0, op_a_i} + {1'b0, op_b_i};
  assign sum_o    = full_sum[31:0];
  assign carry_o  = full_sum[32];
`else
  assign sum_o    = op_a_i + op_b_i;
  assign carry_o  = 1'b0;
`endif

endmodule

// File: rtl/adder_slave_lite_s00_axi.sv
// AXI4-Lite slave with OP_A/OP_B (RW), SUM and STATUS (RO) registers.
// STATUS[0] carries the adder carry-out only when ADDER_CARRY_OUT_EN is defined.
module adder_slave_lite_s00_axi
  import adder_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  // Handshake rules: a transfer happens on the rising edge where VALID and READY
  // are both high. AW and W are accepted together in one cycle; B is held until
  // BREADY. AR is accepted for one cycle, then R holds RDATA stable until RREADY.

  logic       awready_q, awready_d;
  logic       bvalid_q,  bvalid_d;
  logic       arready_q, arready_d;
  logic       rvalid_q,  rvalid_d;
  logic [3:0] araddr_q,  araddr_d;
  data_t      rdata_q,   rdata_d;
  data_t      op_a_q,    op_a_d;
  data_t      op_b_q,    op_b_d;

  data_t      sum;
  logic       carry;
  data_t      status;
  data_t      rd_mux;
  logic       wr_fire;
  logic       rd_fire;
  logic       unused_addr_bits;

  adder_core u_core (
    .op_a_i  (op_a_q),
    .op_b_i  (op_b_q),
    .sum_o   (sum),
    .carry_o (carry)
  );

  assign status = {31'b0, carry};
  assign unused_addr_bits = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    rd_mux = '0;
    case (araddr_q[3:2])
      ADDR_OP_A[3:2]: rd_mux = op_a_q;
      ADDR_OP_B[3:2]: rd_mux = op_b_q;
      ADDR_SUM[3:2]:  rd_mux = sum;
      default:        rd_mux = status;
    endcase
  end

  always_comb begin
    wr_fire   = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    rd_fire   = arready_q && S_AXI_ARVALID;

    awready_d = S_AXI_AWVALID && S_AXI_WVALID && !awready_q && !bvalid_q;
    bvalid_d  = bvalid_q;
    if (wr_fire)                       bvalid_d = 1'b1;
    else if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;

    // SUM and STATUS addresses fall through: the write completes but changes nothing.
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    if (wr_fire && S_AXI_AWADDR[3:2] == ADDR_OP_A[3:2])
      op_a_d = apply_wstrb(op_a_q, S_AXI_WDATA, S_AXI_WSTRB);
    if (wr_fire && S_AXI_AWADDR[3:2] == ADDR_OP_B[3:2])
      op_b_d = apply_wstrb(op_b_q, S_AXI_WDATA, S_AXI_WSTRB);

    arready_d = S_AXI_ARVALID && !arready_q && !rvalid_q;
    araddr_d  = arready_d ? S_AXI_ARADDR[3:0] : araddr_q;

    // RDATA samples pre-edge operands, so a concurrent operand write is not visible.
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_adder_slave_lite_s00_axi.sv
// Directed bench for the AXI4-Lite adder: table of write/read vectors plus
// hand-written stall, concurrency and reset sequences.
module tb_adder_slave_lite_s00_axi;

  logic        clk;
  logic        rst;
  logic [3:0]  awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  int total = 0;
  int bad   = 0;

`ifdef ADDER_CARRY_OUT_EN
  localparam logic [31:0] CARRY_EXP = 32'd1;
`else
  localparam logic [31:0] CARRY_EXP = 32'd0;
`endif

  adder_slave_lite_s00_axi dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(awready && wready) && n < 20);
    if (n >= 20) check("aw_timeout", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    if (n >= 20) check("b_timeout", 32'(bvalid), 32'd1);
    if (bresp !== 2'b00) check("bresp", 32'(bresp), 32'd0);
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!arready && n < 20);
    if (n >= 20) check("ar_timeout", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (n >= 20) check("r_timeout", 32'(rvalid), 32'd1);
    if (rresp !== 2'b00) check("rresp", 32'(rresp), 32'd0);
    d = rdata;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  typedef struct {
    logic        is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_q[$];

  initial begin
    logic [31:0] rd;
    logic [31:0] held;
    int n;

    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    vecs.push_back('{1'b1, 4'h0, 32'd10,        4'hF, 32'd0});
    vecs.push_back('{1'b1, 4'h4, 32'd32,        4'hF, 32'd0});
    vecs.push_back('{1'b0, 4'h8, 32'd0,         4'h0, 32'd42});
    vecs.push_back('{1'b0, 4'h0, 32'd0,         4'h0, 32'd10});
    vecs.push_back('{1'b0, 4'hC, 32'd0,         4'h0, 32'd0});
    vecs.push_back('{1'b1, 4'h0, 32'hFFFFFFFF,  4'hF, 32'd0});
    vecs.push_back('{1'b1, 4'h4, 32'd1,         4'hF, 32'd0});
    vecs.push_back('{1'b0, 4'h8, 32'd0,         4'h0, 32'd0});
    vecs.push_back('{1'b0, 4'hC, 32'd0,         4'h0, CARRY_EXP});
    vecs.push_back('{1'b1, 4'h0, 32'h11223344,  4'hF, 32'd0});
    vecs.push_back('{1'b1, 4'h0, 32'hAABBCCDD,  4'h5, 32'd0});
    vecs.push_back('{1'b0, 4'h0, 32'd0,         4'h0, 32'h11BB33DD});
    vecs.push_back('{1'b0, 4'h8, 32'd0,         4'h0, 32'h11BB33DE});
    vecs.push_back('{1'b1, 4'h8, 32'h00001234,  4'hF, 32'd0});
    vecs.push_back('{1'b0, 4'h8, 32'd0,         4'h0, 32'h11BB33DE});
    vecs.push_back('{1'b1, 4'hC, 32'hFFFFFFFF,  4'hF, 32'd0});
    vecs.push_back('{1'b0, 4'hC, 32'd0,         4'h0, 32'd0});
    vecs.push_back('{1'b1, 4'h6, 32'hF0000000,  4'h8, 32'd0});
    vecs.push_back('{1'b0, 4'h4, 32'd0,         4'h0, 32'hF0000001});
    vecs.push_back('{1'b0, 4'h9, 32'd0,         4'h0, 32'h01BB33DE});
    vecs.push_back('{1'b0, 4'hC, 32'd0,         4'h0, CARRY_EXP});

    repeat (3) tick();
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_resp",    32'({bresp, rresp}), 32'd0);
    rst = 1'b0;
    tick();
    axi_read(4'h8, rd);
    check("rst_sum", rd, 32'd0);

    // table-driven vectors; read expectations go through the scoreboard queue
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        exp_q.push_back(vecs[i].exp);
        axi_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), rd, exp_q.pop_front());
      end
    end

    // B stall: second write must wait until the first response is taken
    axi_write(4'h4, 32'd7, 4'hF);
    awaddr = 4'h0; wdata = 32'd5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!awready && n < 20);
    tick();
    awaddr = 4'h4; wdata = 32'd99;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bstall_bvalid%0d", c), 32'(bvalid), 32'd1);
      check($sformatf("bstall_awready%0d", c), 32'(awready), 32'd0);
      tick();
    end
    bready = 1'b1;
    tick();
    check("bstall_bvalid_clr", 32'(bvalid), 32'd0);
    n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    check("bstall_second_aw", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("bstall_second_b", 32'(bvalid), 32'd1);
    tick();
    bready = 1'b0;
    axi_write(4'h4, 32'd7, 4'hF);
    axi_read(4'h8, rd);
    check("bstall_sum", rd, 32'd12);

    // R stall: RDATA held stable while RREADY low
    araddr = 4'h8; arvalid = 1'b1;
    tick();
    tick();
    arvalid = 1'b0;
    held = 32'd12;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("rstall_rvalid%0d", c), 32'(rvalid), 32'd1);
      check($sformatf("rstall_rdata%0d", c), rdata, held);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rstall_rvalid_clr", 32'(rvalid), 32'd0);

    // concurrent write OP_A and read SUM: read sees pre-write sum
    awaddr = 4'h0; wdata = 32'd100; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h8; arvalid = 1'b1;
    tick();
    check("conc_awready", 32'(awready), 32'd1);
    check("conc_arready", 32'(arready), 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("conc_bvalid", 32'(bvalid), 32'd1);
    check("conc_rvalid", 32'(rvalid), 32'd1);
    check("conc_rdata_old", rdata, 32'd12);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(4'h8, rd);
    check("conc_sum_new", rd, 32'd107);

    // reset mid-read aborts and clears registers
    araddr = 4'h8; arvalid = 1'b1;
    tick();
    tick();
    arvalid = 1'b0;
    check("midrd_rvalid", 32'(rvalid), 32'd1);
    rst = 1'b1;
    tick();
    check("midrd_rvalid_rst", 32'(rvalid), 32'd0);
    check("midrd_arready_rst", 32'(arready), 32'd0);
    rst = 1'b0;
    tick();
    axi_read(4'h0, rd);
    check("post_rst_op_a", rd, 32'd0);
    axi_read(4'h4, rd);
    check("post_rst_op_b", rd, 32'd0);
    axi_read(4'h8, rd);
    check("post_rst_sum", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
